// File: rtl/uart_pkg.sv
// Shared definitions for the UART: register offsets, STATUS bit positions and serialiser states.
package uart_pkg;

    localparam logic [1:0] UART_REG_TXDATA  = 2'd0;
    localparam logic [1:0] UART_REG_STATUS  = 2'd1;
    localparam logic [1:0] UART_REG_DIVISOR = 2'd2;
    localparam logic [1:0] UART_REG_IRQ_EN  = 2'd3;

    localparam int STATUS_BUSY      = 0;
    localparam int STATUS_FULL      = 1;
    localparam int STATUS_EMPTY     = 2;
    localparam int STATUS_OVERFLOW  = 3;
    localparam int STATUS_LEVEL_LSB = 4;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    // A programmed divisor of zero behaves as one clock per bit.
    function automatic logic [15:0] effective_divisor(input logic [15:0] div);
        return (div == 16'd0) ? 16'd1 : div;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with extra-bit pointers; reusable for TX and a future RX path.
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level
);

    logic [DEPTH_LOG2:0] wptr_reg;
    logic [DEPTH_LOG2:0] rptr_reg;
    logic [WIDTH-1:0]    mem [2**DEPTH_LOG2];
    logic                do_push;
    logic                do_pop;

    assign level = wptr_reg - rptr_reg;
    assign empty = (wptr_reg == rptr_reg);
    assign full  = (wptr_reg[DEPTH_LOG2] != rptr_reg[DEPTH_LOG2]) &&
                   (wptr_reg[DEPTH_LOG2-1:0] == rptr_reg[DEPTH_LOG2-1:0]);

    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_reg <= '0;
            rptr_reg <= '0;
        end else begin
            if (do_push) wptr_reg <= wptr_reg + 1'b1;
            if (do_pop)  rptr_reg <= rptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr_reg[DEPTH_LOG2-1:0]] <= wdata;
    end

    // Head word is visible combinationally so the serialiser can load it on the pop cycle.
    assign rdata = mem[rptr_reg[DEPTH_LOG2-1:0]];

endmodule

// File: rtl/uart_tx_wb.sv
// Wishbone classic UART transmitter (8N1) with TX FIFO.
// Define UART_TX_IRQ_EN to add irq_o and the IRQ_ENABLE register.
module uart_tx_wb
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS    = 32'h5000_0000,
    parameter int          FIFO_DEPTH_LOG2 = 3,
    parameter logic [15:0] DEFAULT_DIVISOR = 16'd104
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        stb_i,
    input  logic        cyc_i,
    input  logic [31:0] adr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    input  logic        we_i,
    output logic        ack_o,
    output logic        err_o,
    output logic        rty_o,
    output logic        tx_o
`ifdef UART_TX_IRQ_EN
    ,
    output logic        irq_o
`endif
);

    logic                     hit;
    logic                     ack_reg;
    logic                     acc;
    logic                     wr_acc;
    logic                     rd_acc;
    logic [1:0]               reg_sel;
    logic                     push_req;
    logic [31:0]              rdata;
    logic [15:0]              divisor_reg;
    logic [15:0]              div_eff;
    logic                     overflow_reg;
    logic                     fifo_pop;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [7:0]               fifo_rdata;
    logic [FIFO_DEPTH_LOG2:0] fifo_level;
    tx_state_t                state_reg;
    logic                     tx_reg;
    logic [7:0]               shift_reg;
    logic [2:0]               bit_cnt_reg;
    logic [15:0]              baud_cnt_reg;
    logic                     baud_zero;
    logic                     unused_bits;

    assign unused_bits = ^{adr_i[1:0], dat_i[31:16], sel_i[3:2]};

    assign hit     = cyc_i & stb_i & (adr_i[31:4] == BASE_ADDRESS[31:4]);
    assign acc     = ack_reg & hit;
    assign wr_acc  = acc & we_i;
    assign rd_acc  = acc & ~we_i;
    assign reg_sel = adr_i[3:2];

    assign push_req = wr_acc && (reg_sel == UART_REG_TXDATA) && sel_i[0];

    // The ~ack_reg term forces a one-cycle gap so a held strobe is acked once per access.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ack_reg <= 1'b0;
        else         ack_reg <= hit & ~ack_reg;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            divisor_reg  <= DEFAULT_DIVISOR;
            overflow_reg <= 1'b0;
        end else begin
            if (wr_acc && reg_sel == UART_REG_DIVISOR) begin
                if (sel_i[0]) divisor_reg[7:0]  <= dat_i[7:0];
                if (sel_i[1]) divisor_reg[15:8] <= dat_i[15:8];
            end
            if (push_req && fifo_full && !fifo_pop)
                overflow_reg <= 1'b1;
            else if (rd_acc && reg_sel == UART_REG_STATUS)
                overflow_reg <= 1'b0;
        end
    end

`ifdef UART_TX_IRQ_EN
    logic irq_en_reg;
    logic irq_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_en_reg <= 1'b0;
            irq_reg    <= 1'b0;
        end else begin
            if (wr_acc && reg_sel == UART_REG_IRQ_EN && sel_i[0])
                irq_en_reg <= dat_i[0];
            irq_reg <= irq_en_reg & fifo_empty & (state_reg == IDLE);
        end
    end

    assign irq_o = irq_reg;
`endif

    always_comb begin
        rdata = '0;
        case (reg_sel)
            UART_REG_STATUS: begin
                rdata[STATUS_BUSY]              = (state_reg != IDLE);
                rdata[STATUS_FULL]              = fifo_full;
                rdata[STATUS_EMPTY]             = fifo_empty;
                rdata[STATUS_OVERFLOW]          = overflow_reg;
                rdata[STATUS_LEVEL_LSB +: 4]    = 4'(fifo_level);
            end
            UART_REG_DIVISOR: rdata[15:0] = divisor_reg;
`ifdef UART_TX_IRQ_EN
            UART_REG_IRQ_EN:  rdata[0] = irq_en_reg;
`endif
            default: ;
        endcase
    end

    assign dat_o = ack_reg ? rdata : 'z;
    assign ack_o = ack_reg;
    assign err_o = hit ? 1'b0 : 1'bz;
    assign rty_o = hit ? 1'b0 : 1'bz;

    sync_fifo #(
        .WIDTH      (8),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .push  (push_req),
        .pop   (fifo_pop),
        .wdata (dat_i[7:0]),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign div_eff   = effective_divisor(divisor_reg);
    assign baud_zero = (baud_cnt_reg == 16'd0);
    // Pop when idle, or at the very end of a stop bit so frames run back to back.
    assign fifo_pop  = ~fifo_empty &
                       ((state_reg == IDLE) | ((state_reg == STOP) & baud_zero));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg    <= IDLE;
            tx_reg       <= 1'b1;
            shift_reg    <= '0;
            bit_cnt_reg  <= '0;
            baud_cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    tx_reg <= 1'b1;
                    if (fifo_pop) begin
                        shift_reg    <= fifo_rdata;
                        tx_reg       <= 1'b0;
                        baud_cnt_reg <= div_eff - 16'd1;
                        state_reg    <= START;
                    end
                end
                START: begin
                    if (baud_zero) begin
                        tx_reg       <= shift_reg[0];
                        shift_reg    <= shift_reg >> 1;
                        bit_cnt_reg  <= 3'd0;
                        baud_cnt_reg <= div_eff - 16'd1;
                        state_reg    <= DATA;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg - 16'd1;
                    end
                end
                DATA: begin
                    if (baud_zero) begin
                        baud_cnt_reg <= div_eff - 16'd1;
                        if (bit_cnt_reg == 3'd7) begin
                            tx_reg    <= 1'b1;
                            state_reg <= STOP;
                        end else begin
                            tx_reg      <= shift_reg[0];
                            shift_reg   <= shift_reg >> 1;
                            bit_cnt_reg <= bit_cnt_reg + 3'd1;
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg - 16'd1;
                    end
                end
                STOP: begin
                    if (baud_zero) begin
                        if (fifo_pop) begin
                            shift_reg    <= fifo_rdata;
                            tx_reg       <= 1'b0;
                            baud_cnt_reg <= div_eff - 16'd1;
                            state_reg    <= START;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg - 16'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign tx_o = tx_reg;

endmodule

// File: tb/tb_uart_tx_wb.sv
// Self-checking bench for uart_tx_wb: a frame-schedule model predicts tx_o every cycle and register reads.
module tb_uart_tx_wb;

    localparam logic [31:0] BASE = 32'h5000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stb = 1'b0;
    logic        cyc = 1'b0;
    logic        we = 1'b0;
    logic [31:0] adr = '0;
    logic [3:0]  sel = '0;
    logic [31:0] wdat = '0;
    wire  [31:0] rdat;
    wire         ack;
    wire         err;
    wire         rty;
    wire         tx;
`ifdef UART_TX_IRQ_EN
    wire         irq;
`endif

    uart_tx_wb dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .stb_i  (stb),
        .cyc_i  (cyc),
        .adr_i  (adr),
        .sel_i  (sel),
        .dat_i  (wdat),
        .dat_o  (rdat),
        .we_i   (we),
        .ack_o  (ack),
        .err_o  (err),
        .rty_o  (rty),
`ifdef UART_TX_IRQ_EN
        .irq_o  (irq),
`endif
        .tx_o   (tx)
    );

    always #5 clk = ~clk;

    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    int n_vec = 0;
    int n_bad = 0;

    // Model: every accepted byte becomes a scheduled frame (ack cycle, start cycle, divisor, data).
    int         f_ack[$];
    int         f_start[$];
    int         f_div[$];
    logic [7:0] f_data[$];
    logic [15:0] m_div_raw;
    bit          m_ovf;
    bit          m_irq_en;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cyc_n, act, exp);
        end
    endtask

    function automatic void model_reset();
        f_ack.delete(); f_start.delete(); f_div.delete(); f_data.delete();
        m_div_raw = 16'd104;
        m_ovf     = 1'b0;
        m_irq_en  = 1'b0;
    endfunction

    function automatic int eff_div();
        return (m_div_raw == 16'd0) ? 1 : int'(m_div_raw);
    endfunction

    // A frame's byte sits in the FIFO until the cycle before its start bit.
    function automatic void model_push(input int a, input logic [7:0] b);
        int occ = 0;
        bit pop_now = 0;
        int st;
        foreach (f_start[i]) begin
            if (f_start[i] - 1 >= a) occ++;
            if (f_start[i] - 1 == a) pop_now = 1;
        end
        if (occ < 8 || pop_now) begin
            st = a + 2;
            if (f_start.size() > 0) begin
                int last_end = f_start[$] + 10 * f_div[$];
                if (last_end > st) st = last_end;
            end
            f_ack.push_back(a); f_start.push_back(st);
            f_div.push_back(eff_div()); f_data.push_back(b);
        end else begin
            m_ovf = 1'b1;
        end
    endfunction

    function automatic logic model_tx(input int t);
        foreach (f_start[i]) begin
            int off = t - f_start[i];
            if (off >= 0 && off < 10 * f_div[i]) begin
                int b = off / f_div[i];
                if (b == 0) return 1'b0;
                if (b == 9) return 1'b1;
                return f_data[i][b-1];
            end
        end
        return 1'b1;
    endfunction

    function automatic logic [31:0] model_read(input int r, input int t);
        int lvl = 0;
        bit busy = 0;
        case (r)
            1: begin
                foreach (f_start[i]) begin
                    if (f_ack[i] < t && f_start[i] - 1 >= t) lvl++;
                    if (t >= f_start[i] && t < f_start[i] + 10 * f_div[i]) busy = 1;
                end
                return {24'b0, 4'(lvl), m_ovf, (lvl == 0), (lvl == 8), busy};
            end
            2: return {16'b0, m_div_raw};
`ifdef UART_TX_IRQ_EN
            3: return {31'b0, m_irq_en};
`endif
            default: return 32'b0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (cyc_n > 0) chk("tx_model", 32'(tx), 32'(model_tx(cyc_n)));
    end

    // Call at #1 after a posedge; returns at #1 after the posedge following the ack cycle.
    task automatic wb(input bit w, input int r, input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] v, output int t_ack);
        cyc = 1; stb = 1; we = w; adr = BASE + 32'(r * 4); wdat = d; sel = s;
        @(posedge clk); #1;
        t_ack = cyc_n;
        chk("ack", 32'(ack), 32'(1));
        chk("err", 32'(err), 32'(0));
        v = rdat;
        @(posedge clk); #1;
        cyc = 0; stb = 0; we = 0;
        chk("ack_once", 32'(ack), 32'(0));
    endtask

    task automatic wr(input int r, input logic [31:0] d, input logic [3:0] s, output int t_ack);
        logic [31:0] v;
        wb(1'b1, r, d, s, v, t_ack);
        if (r == 0 && s[0]) model_push(t_ack, d[7:0]);
        if (r == 2) begin
            if (s[0]) m_div_raw[7:0]  = d[7:0];
            if (s[1]) m_div_raw[15:8] = d[15:8];
        end
        if (r == 3 && s[0]) m_irq_en = d[0];
    endtask

    task automatic rd(input int r, input string nm, output logic [31:0] v);
        int ta;
        wb(1'b0, r, 32'h0, 4'hF, v, ta);
        chk(nm, v, model_read(r, ta));
        if (r == 1) m_ovf = 1'b0;
    endtask

    task automatic goto_cycle(input int t);
        while (cyc_n < t) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [31:0] v;
        logic [7:0]  pat;
        int ta, t0, s;

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", 32'(tx), 32'(1));
        chk("rst_ack", 32'(ack), 32'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;
        rd(1, "rst_status", v);  chk("rst_status_lit", v, 32'h04);
        rd(2, "rst_divisor", v); chk("rst_divisor_lit", v, 32'd104);

        // Single 0x55 frame at 4 clocks per bit.
        wr(2, 32'd4, 4'b0011, ta);
        rd(2, "div4", v); chk("div4_lit", v, 32'd4);
        wr(0, 32'h55, 4'b0001, ta);
        s = ta + 2;
        pat = 8'h55;
        goto_cycle(s - 1); chk("t1_before_start", 32'(tx), 32'(1));
        goto_cycle(s);     chk("t1_start", 32'(tx), 32'(0));
        goto_cycle(s + 3); chk("t1_start_end", 32'(tx), 32'(0));
        for (int b = 0; b < 8; b++) begin
            goto_cycle(s + 4 * (b + 1));
            chk("t1_bit", 32'(tx), 32'(pat[b]));
        end
        goto_cycle(s + 36); chk("t1_stop", 32'(tx), 32'(1));
        goto_cycle(s + 45);

        // Nine back-to-back writes while idle: first pops at once, eight fill the FIFO.
        for (int i = 0; i < 9; i++) begin
            wr(0, 32'(i), 4'b0001, ta);
            if (i == 0) t0 = ta;
        end
        rd(1, "t2_status", v); chk("t2_status_lit", v, 32'h83);
        s = t0 + 2;
        goto_cycle(s + 39); chk("t2_stop_last", 32'(tx), 32'(1));
        goto_cycle(s + 40); chk("t2_b2b_start", 32'(tx), 32'(0));
        goto_cycle(s + 44); chk("t2_b2b_bit0", 32'(tx), 32'(1));
        goto_cycle(s + 360 + 3);
        rd(1, "t2_drained", v); chk("t2_drained_lit", v, 32'h04);

        // Register corner cases.
        rd(0, "txdata_read", v); chk("txdata_read_lit", v, 32'h0);
        wr(0, 32'h77, 4'b1110, ta);
        rd(1, "nosel_status", v); chk("nosel_status_lit", v, 32'h04);
        wr(3, 32'h1, 4'b0001, ta);
        rd(3, "reg3", v);
`ifdef UART_TX_IRQ_EN
        chk("reg3_lit", v, 32'h1);
`else
        chk("reg3_lit", v, 32'h0);
`endif
        adr = BASE + 32'h10; cyc = 1; stb = 1; we = 0;
        repeat (2) begin
            @(posedge clk); #1;
            chk("miss_ack", 32'(ack), 32'(0));
        end
        cyc = 0; stb = 0;
        @(posedge clk); #1;

        // Divisor 0 behaves as 1: ten-cycle frame of 0xA5.
        wr(2, 32'd0, 4'b0011, ta);
        rd(2, "div0", v); chk("div0_lit", v, 32'd0);
        wr(0, 32'hA5, 4'b0001, ta);
        s = ta + 2;
        pat = 8'hA5;
        goto_cycle(s); chk("t4_start", 32'(tx), 32'(0));
        for (int b = 0; b < 8; b++) begin
            goto_cycle(s + 1 + b);
            chk("t4_bit", 32'(tx), 32'(pat[b]));
        end
        goto_cycle(s + 9);  chk("t4_stop", 32'(tx), 32'(1));
        goto_cycle(s + 10); chk("t4_idle", 32'(tx), 32'(1));
        goto_cycle(s + 14);

`ifdef UART_TX_IRQ_EN
        wr(2, 32'd4, 4'b0011, ta);
        goto_cycle(cyc_n + 3);
        chk("irq_idle", 32'(irq), 32'(1));
        wr(0, 32'h3C, 4'b0001, ta);
        s = ta + 2;
        goto_cycle(ta + 2);  chk("irq_drop", 32'(irq), 32'(0));
        goto_cycle(s + 20);  chk("irq_frame", 32'(irq), 32'(0));
        goto_cycle(s + 42);  chk("irq_done", 32'(irq), 32'(1));
`endif

        // Overflow with a slow divisor, then reset in the middle of the first frame.
        wr(2, 32'd50, 4'b0011, ta);
        for (int i = 0; i < 10; i++) begin
            wr(0, 32'hC0 + 32'(i), 4'b0001, ta);
            if (i == 0) t0 = ta;
        end
        rd(1, "ovf_status", v);  chk("ovf_status_lit", v, 32'h8B);
        rd(1, "ovf_cleared", v); chk("ovf_cleared_lit", v, 32'h83);
        s = t0 + 2;
        goto_cycle(s + 150);
        chk("pre_rst_low", 32'(tx), 32'(0));
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_async_tx", 32'(tx), 32'(1));
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_tx", 32'(tx), 32'(1));
        rst_n = 1'b1;
        @(posedge clk); #1;
        rd(1, "post_rst_status", v);  chk("post_rst_status_lit", v, 32'h04);
        rd(2, "post_rst_divisor", v); chk("post_rst_divisor_lit", v, 32'd104);
`ifdef UART_TX_IRQ_EN
        goto_cycle(cyc_n + 2);
        chk("post_rst_irq", 32'(irq), 32'(0));
`endif
        goto_cycle(cyc_n + 10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
